// File: rtl/bus_sequencer.sv
// Upstream sequencer for the PlayBus stage: walks an address range and issues
// one dynamic bus operation per address, waiting for the stage to return idle.
module bus_sequencer (
  input  logic       CK2HZ,
  input  logic       CLR,
  input  logic       START,
  input  logic [2:0] FUNC_IN,
  input  logic [3:0] ADD_FIRST,
  input  logic [3:0] ADD_LAST,
  input  logic [1:0] St,
  output logic [3:0] ADD,
  output logic [2:0] FUNC,
  output logic       GO,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [1:0] SQ
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic       s1, s2, s3;
  logic       start_edge, func_ok;
  logic [3:0] addr, addr_next, last, last_next;
  logic [2:0] func_r, func_next, wd, wd_next;
  logic       go_next, done_next, err_next;

  // START is a raw button; s3 only remembers s2 for edge detection
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= START;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_edge = s2 & ~s3;
  assign func_ok    = (FUNC_IN == 3'd3) || (FUNC_IN == 3'd4) || (FUNC_IN == 3'd5);

  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      addr   <= 4'd0;
      last   <= 4'd0;
      func_r <= 3'd0;
      wd     <= 3'd0;
      GO     <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_next;
      addr   <= addr_next;
      last   <= last_next;
      func_r <= func_next;
      wd     <= wd_next;
      GO     <= go_next;
      DONE   <= done_next;
      ERR    <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr;
    last_next  = last;
    func_next  = func_r;
    wd_next    = wd;
    go_next    = GO;
    done_next  = DONE;
    err_next   = ERR;
    case (state)
      IDLE: begin
        go_next = 1'b0;
        if (start_edge && (St == 2'd0) && func_ok) begin
          addr_next  = ADD_FIRST;
          func_next  = FUNC_IN;
          last_next  = (FUNC_IN == 3'd5) ? ADD_FIRST : ADD_LAST;
          err_next   = 1'b0;
          wd_next    = 3'd0;
          go_next    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (St == 2'd3) begin
          go_next    = 1'b0;
          wd_next    = 3'd0;
          state_next = RELEASE;
        end else if (wd == 3'd7) begin
          err_next   = 1'b1;
          go_next    = 1'b0;
          state_next = IDLE;
        end else begin
          wd_next = wd + 3'd1;
        end
      end
      RELEASE: begin
        if (St == 2'd0) begin
          if (addr == last) begin
            done_next  = 1'b1;
            state_next = FINISH;
          end else begin
            addr_next  = addr + 4'd1;
            go_next    = 1'b1;
            wd_next    = 3'd0;
            state_next = ISSUE;
          end
        end else if (wd == 3'd7) begin
          err_next   = 1'b1;
          go_next    = 1'b0;
          state_next = IDLE;
        end else begin
          wd_next = wd + 3'd1;
        end
      end
      FINISH: begin
        go_next   = 1'b0;
        done_next = 1'b1;
        if (!s2) begin
          done_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // In IDLE the switches pass straight through so static functions work directly
  assign ADD  = (state == IDLE) ? ADD_FIRST : addr;
  assign FUNC = (state == IDLE) ? FUNC_IN : func_r;
  assign BUSY = (state != IDLE);
  assign SQ   = state;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer against a behavioural PlayBus stage model.
module tb_bus_sequencer;

  logic       CK2HZ, CLR, START;
  logic [2:0] FUNC_IN;
  logic [3:0] ADD_FIRST, ADD_LAST;
  logic [1:0] St;
  logic [3:0] ADD;
  logic [2:0] FUNC;
  logic       GO, BUSY, DONE, ERR;
  logic [1:0] SQ;

  int n_cmp = 0;
  int n_bad = 0;

  bus_sequencer dut (
    .CK2HZ(CK2HZ), .CLR(CLR), .START(START), .FUNC_IN(FUNC_IN),
    .ADD_FIRST(ADD_FIRST), .ADD_LAST(ADD_LAST), .St(St), .ADD(ADD),
    .FUNC(FUNC), .GO(GO), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .SQ(SQ)
  );

  initial CK2HZ = 1'b0;
  always #5 CK2HZ = ~CK2HZ;

  // Stage model: 0 idle -> 1 -> 2 -> 3, leaves 3 once GO drops; mode forces St
  logic [1:0] st_model;
  int         mode = 0;
  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) st_model <= 2'd0;
    else begin
      case (st_model)
        2'd0: if (GO) st_model <= 2'd1;
        2'd1: st_model <= 2'd2;
        2'd2: st_model <= 2'd3;
        default: if (!GO) st_model <= 2'd0;
      endcase
    end
  end
  assign St = (mode == 1) ? 2'd0 : (mode == 2) ? 2'd2 : st_model;

  // GO pulse monitor: rise cycle, address at rise, pulse length
  int         cyc = 0;
  int         n_rise = 0;
  int         add_glitch = 0;
  int         rise_cyc [64];
  logic [3:0] rise_add [64];
  int         high_len [64];
  logic       go_d = 1'b0;
  always @(negedge CK2HZ) begin
    cyc++;
    if (GO && !go_d && n_rise < 64) begin
      rise_cyc[n_rise] = cyc;
      rise_add[n_rise] = ADD;
      high_len[n_rise] = 1;
      n_rise++;
    end else if (GO && go_d && n_rise > 0) begin
      high_len[n_rise-1]++;
      if (ADD != rise_add[n_rise-1]) add_glitch++;
    end
    go_d = GO;
  end

  task automatic tick();
    @(negedge CK2HZ);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] fn, input logic [3:0] first,
                               input logic [3:0] lst, input logic start);
    FUNC_IN   = fn;
    ADD_FIRST = first;
    ADD_LAST  = lst;
    START     = start;
  endtask

  // Runs one accepted sequence to completion and checks every GO pulse
  task automatic runSequence(input logic [2:0] fn, input logic [3:0] first,
                             input logic [3:0] lst, input string tag);
    int         base, c0, exp_n, waited, got_n;
    logic [3:0] span, exp_add;
    logic       scrambled, func_bad;
    applyStimulus(fn, first, lst, 1'b1);
    base = n_rise;
    c0 = cyc;
    span = lst - first;
    exp_n = (fn == 3'd5) ? 1 : int'(span) + 1;
    waited = 0;
    scrambled = 1'b0;
    func_bad = 1'b0;
    while (!DONE && waited < 200) begin
      tick();
      waited++;
      if (n_rise > base && !scrambled) begin
        applyStimulus(3'd0, 4'd9, 4'd9, 1'b1);
        scrambled = 1'b1;
      end
      if (BUSY && FUNC != fn) func_bad = 1'b1;
    end
    checkOutput({tag, "_done"}, DONE, 1);
    got_n = n_rise - base;
    checkOutput({tag, "_ops"}, got_n, exp_n);
    if (got_n > 0) checkOutput({tag, "_latency"}, rise_cyc[base] - c0, 3);
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      exp_add = first + i[3:0];
      checkOutput($sformatf("%s_add%0d", tag, i), rise_add[base+i], exp_add);
      checkOutput($sformatf("%s_len%0d", tag, i), high_len[base+i], 4);
      if (i > 0)
        checkOutput($sformatf("%s_gap%0d", tag, i), rise_cyc[base+i] - rise_cyc[base+i-1], 6);
    end
    checkOutput({tag, "_func_held"}, func_bad, 0);
    checkOutput({tag, "_sq_finish"}, SQ, 3);
    checkOutput({tag, "_busy_finish"}, BUSY, 1);
    checkOutput({tag, "_err"}, ERR, 0);
    tick();
    tick();
    checkOutput({tag, "_done_held"}, DONE, 1);
    START = 1'b0;
    tick();
    tick();
    checkOutput({tag, "_sq_pre_idle"}, SQ, 3);
    tick();
    checkOutput({tag, "_sq_idle"}, SQ, 0);
    checkOutput({tag, "_done_clr"}, DONE, 0);
    checkOutput({tag, "_busy_idle"}, BUSY, 0);
  endtask

  initial begin
    int  base, waited;
    logic bad;

    CLR = 1'b1;
    applyStimulus(3'd0, 4'd0, 4'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_go", GO, 0);
    checkOutput("rst_sq", SQ, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_done", DONE, 0);
    checkOutput("rst_err", ERR, 0);
    CLR = 1'b0;
    tick();
    tick();

    runSequence(3'd4, 4'd5, 4'd5, "single");
    runSequence(3'd3, 4'd14, 4'd1, "wrap");
    runSequence(3'd5, 4'd2, 4'd9, "oneshot");

    // Static function: start ignored, switches pass through
    applyStimulus(3'd1, 4'd7, 4'd8, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (GO || SQ != 2'd0) bad = 1'b1;
    end
    checkOutput("static_ignored", bad, 0);
    checkOutput("static_func", FUNC, 1);
    checkOutput("static_add", ADD, 7);
    START = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Stage not idle: start ignored
    mode = 2;
    applyStimulus(3'd4, 4'd3, 4'd3, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (GO || SQ != 2'd0) bad = 1'b1;
    end
    checkOutput("busy_stage_ignored", bad, 0);
    START = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mode = 0;
    tick();

    // Watchdog: stage never leaves idle
    mode = 1;
    base = n_rise;
    applyStimulus(3'd4, 4'd6, 4'd6, 1'b1);
    waited = 0;
    while (!ERR && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("wd_err", ERR, 1);
    checkOutput("wd_go", GO, 0);
    checkOutput("wd_sq", SQ, 0);
    checkOutput("wd_pulses", n_rise - base, 1);
    if (n_rise > base) checkOutput("wd_go_len", high_len[base], 8);
    START = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mode = 0;
    tick();
    checkOutput("wd_err_held", ERR, 1);
    runSequence(3'd5, 4'd3, 4'd3, "after_wd");

    // Reset in RELEASE of the second address of 0..3
    applyStimulus(3'd3, 4'd0, 4'd3, 1'b1);
    base = n_rise;
    waited = 0;
    while (!(n_rise - base >= 2 && SQ == 2'd2) && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput("mid_release_reached", SQ, 2);
    CLR = 1'b1;
    #1;
    checkOutput("clr_go", GO, 0);
    checkOutput("clr_sq", SQ, 0);
    checkOutput("clr_busy", BUSY, 0);
    checkOutput("clr_done", DONE, 0);
    checkOutput("clr_err", ERR, 0);
    checkOutput("clr_add", ADD, 0);
    tick();
    tick();
    base = n_rise;
    CLR = 1'b0;
    tick();
    tick();
    checkOutput("post_clr_no_go", n_rise - base, 0);
    checkOutput("post_clr_sq", SQ, 0);
    START = 1'b0;
    waited = 0;
    while ((BUSY || SQ != 2'd0) && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput("final_idle", SQ, 0);

    checkOutput("add_stable", add_glitch, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
